// File: rtl/contador_salida.sv
// Output drain stage: round-robin pops from the D0/D1 destination FIFOs, registered output stream
// and saturating per-destination word counters. Optional misroute counter: MISROUTE_CHECK_EN.
module contador_salida #(
    parameter int unsigned BW = 6,
    parameter int unsigned CW = 5
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          init,
    input  logic          pause,
    input  logic          idle,
    input  logic          D0_empty,
    input  logic          D1_empty,
    input  logic [BW-1:0] D0_data_out,
    input  logic [BW-1:0] D1_data_out,
    output logic          D0_rd,
    output logic          D1_rd,
    output logic [BW-1:0] data_out,
    output logic          valid_out,
    output logic          dest_out,
    input  logic          req,
    input  logic [1:0]    idx,
    output logic [CW-1:0] cnt_data,
    output logic          cnt_valid
);

    localparam logic [CW-1:0] CntMax = {CW{1'b1}};

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CntMax) ? v : v + CW'(1);
    endfunction

    // Arbitration state: last FIFO served; reset value 1 makes D0 the first preference.
    logic last_q, last_d;

    // Which FIFO was popped on the previous edge; its data is valid this cycle.
    logic cap0_q, cap1_q;

    logic [BW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          dest_q, dest_d;

    logic [CW-1:0] cnt_d0_q, cnt_d0_d;
    logic [CW-1:0] cnt_d1_q, cnt_d1_d;
    logic [CW-1:0] cnt_tot_q, cnt_tot_d;
    logic [CW-1:0] mis_val;

    logic [CW-1:0] cnt_data_q, cnt_data_d;
    logic          cnt_valid_q, cnt_valid_d;

    logic          cand0, cand1;
    logic          cap;
    logic          cap_src;
    logic [BW-1:0] cap_word;

    // Pop strobes are combinational so a word can be drained every cycle.
    always_comb begin
        D0_rd = 1'b0;
        D1_rd = 1'b0;
        cand0 = reset_L && !D0_empty && !pause && !init;
        cand1 = reset_L && !D1_empty && !pause && !init;
        if (cand0 && cand1) begin
            if (last_q) begin
                D0_rd = 1'b1;
            end else begin
                D1_rd = 1'b1;
            end
        end else if (cand0) begin
            D0_rd = 1'b1;
        end else if (cand1) begin
            D1_rd = 1'b1;
        end
    end

    always_comb begin
        last_d = last_q;
        if (init) begin
            last_d = 1'b1;
        end else if (D0_rd) begin
            last_d = 1'b0;
        end else if (D1_rd) begin
            last_d = 1'b1;
        end
    end

    assign cap      = cap0_q || cap1_q;
    assign cap_src  = cap1_q;
    assign cap_word = cap1_q ? D1_data_out : D0_data_out;

    always_comb begin
        valid_d = cap;
        data_d  = data_q;
        dest_d  = dest_q;
        if (cap) begin
            data_d = cap_word;
            dest_d = cap_src;
        end
    end

    // A clear on init takes priority over a capture landing in the same cycle.
    always_comb begin
        cnt_d0_d  = cnt_d0_q;
        cnt_d1_d  = cnt_d1_q;
        cnt_tot_d = cnt_tot_q;
        if (init) begin
            cnt_d0_d  = '0;
            cnt_d1_d  = '0;
            cnt_tot_d = '0;
        end else if (cap) begin
            cnt_tot_d = sat_inc(cnt_tot_q);
            if (cap_src) begin
                cnt_d1_d = sat_inc(cnt_d1_q);
            end else begin
                cnt_d0_d = sat_inc(cnt_d0_q);
            end
        end
    end

`ifdef MISROUTE_CHECK_EN
    logic [CW-1:0] cnt_mis_q, cnt_mis_d;
    logic          misroute;

    // Bit BW-2 of each word carries the destination it was routed for.
    assign misroute = cap_word[BW-2] != cap_src;

    always_comb begin
        cnt_mis_d = cnt_mis_q;
        if (init) begin
            cnt_mis_d = '0;
        end else if (cap && misroute) begin
            cnt_mis_d = sat_inc(cnt_mis_q);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_mis_q <= '0;
        end else begin
            cnt_mis_q <= cnt_mis_d;
        end
    end

    assign mis_val = cnt_mis_q;
`else
    assign mis_val = '0;
`endif

    // Readout samples the registered counters, so it returns pre-increment values.
    always_comb begin
        cnt_valid_d = idle && req;
        cnt_data_d  = '0;
        if (idle && req) begin
            unique case (idx)
                2'd0:    cnt_data_d = cnt_d0_q;
                2'd1:    cnt_data_d = cnt_d1_q;
                2'd2:    cnt_data_d = cnt_tot_q;
                default: cnt_data_d = mis_val;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            last_q      <= 1'b1;
            cap0_q      <= 1'b0;
            cap1_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            dest_q      <= 1'b0;
            cnt_d0_q    <= '0;
            cnt_d1_q    <= '0;
            cnt_tot_q   <= '0;
            cnt_data_q  <= '0;
            cnt_valid_q <= 1'b0;
        end else begin
            last_q      <= last_d;
            cap0_q      <= D0_rd;
            cap1_q      <= D1_rd;
            data_q      <= data_d;
            valid_q     <= valid_d;
            dest_q      <= dest_d;
            cnt_d0_q    <= cnt_d0_d;
            cnt_d1_q    <= cnt_d1_d;
            cnt_tot_q   <= cnt_tot_d;
            cnt_data_q  <= cnt_data_d;
            cnt_valid_q <= cnt_valid_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign dest_out  = dest_q;
    assign cnt_data  = cnt_data_q;
    assign cnt_valid = cnt_valid_q;

endmodule

// File: tb/tb_contador_salida.sv
// Randomized bench for contador_salida: FIFO models, per-cycle reference model of the drain
// stream and counters, plus directed checks of the documented scenarios.
module tb_contador_salida;

    localparam int unsigned BW = 6;
    localparam int unsigned CW = 5;
    localparam int CntMax = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          init = 1'b0;
    logic          pause = 1'b0;
    logic          idle = 1'b0;
    logic          req = 1'b0;
    logic [1:0]    idx = 2'd0;
    logic          D0_empty = 1'b1;
    logic          D1_empty = 1'b1;
    logic [BW-1:0] D0_data_out = '0;
    logic [BW-1:0] D1_data_out = '0;
    logic          D0_rd, D1_rd;
    logic [BW-1:0] data_out;
    logic          valid_out, dest_out;
    logic [CW-1:0] cnt_data;
    logic          cnt_valid;

    contador_salida #(.BW(BW), .CW(CW)) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .init        (init),
        .pause       (pause),
        .idle        (idle),
        .D0_empty    (D0_empty),
        .D1_empty    (D1_empty),
        .D0_data_out (D0_data_out),
        .D1_data_out (D1_data_out),
        .D0_rd       (D0_rd),
        .D1_rd       (D1_rd),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .dest_out    (dest_out),
        .req         (req),
        .idx         (idx),
        .cnt_data    (cnt_data),
        .cnt_valid   (cnt_valid)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // FIFO contents as seen by the DUT, and the model's own copy of what was pushed.
    logic [BW-1:0] fq0[$], fq1[$];
    logic [BW-1:0] mq0[$], mq1[$];

    // Registered-read FIFOs: data valid the cycle after the pop strobe.
    always @(posedge clk) begin
        if (D0_rd && fq0.size() > 0) D0_data_out <= fq0.pop_front();
        if (D1_rd && fq1.size() > 0) D1_data_out <= fq1.pop_front();
        D0_empty <= (fq0.size() == 0);
        D1_empty <= (fq1.size() == 0);
    end

    // Reference model state.
    logic          m_last = 1'b1;
    logic          m_pv = 1'b0;
    logic          m_ps = 1'b0;
    logic [BW-1:0] m_pw = '0;
    int            m_cnt[4] = '{0, 0, 0, 0};
    logic          e_valid = 1'b0, e_dest = 1'b0, e_cvalid = 1'b0;
    logic [BW-1:0] e_data = '0;
    logic [CW-1:0] e_cdata = '0;
    logic          c0, c1, x0, x1;

    function automatic int sat(input int v);
        return (v < CntMax) ? v + 1 : v;
    endfunction

    function automatic int model_read(input int i);
`ifdef MISROUTE_CHECK_EN
        return m_cnt[i];
`else
        return (i == 3) ? 0 : m_cnt[i];
`endif
    endfunction

    // Mid-cycle: check what the last edge produced, then predict the next edge.
    always @(negedge clk) begin
        if (!reset_L) begin
            m_last = 1'b1;
            m_pv = 1'b0;
            m_ps = 1'b0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            e_valid = 1'b0;
            e_dest = 1'b0;
            e_data = '0;
            e_cvalid = 1'b0;
            e_cdata = '0;
        end
        check_value("valid_out", valid_out, e_valid);
        check_value("data_out", data_out, e_data);
        check_value("dest_out", dest_out, e_dest);
        check_value("cnt_valid", cnt_valid, e_cvalid);
        check_value("cnt_data", cnt_data, e_cdata);

        c0 = reset_L && !D0_empty && !pause && !init;
        c1 = reset_L && !D1_empty && !pause && !init;
        x0 = c0 && (!c1 || m_last);
        x1 = c1 && !x0;
        check_value("D0_rd", D0_rd, x0);
        check_value("D1_rd", D1_rd, x1);

        if (reset_L) begin
            e_cvalid = idle && req;
            e_cdata = (idle && req) ? CW'(model_read(int'(idx))) : '0;
            e_valid = m_pv;
            if (m_pv) begin
                e_data = m_pw;
                e_dest = m_ps;
            end
            if (init) begin
                for (int i = 0; i < 4; i++) m_cnt[i] = 0;
                m_last = 1'b1;
            end else if (m_pv) begin
                m_cnt[m_ps ? 1 : 0] = sat(m_cnt[m_ps ? 1 : 0]);
                m_cnt[2] = sat(m_cnt[2]);
                if (m_pw[BW-2] != m_ps) m_cnt[3] = sat(m_cnt[3]);
            end
            m_pv = x0 || x1;
            m_ps = x1;
            if (x0 && mq0.size() > 0) m_pw = mq0.pop_front();
            if (x1 && mq1.size() > 0) m_pw = mq1.pop_front();
            if (x0) m_last = 1'b0;
            if (x1) m_last = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input logic [BW-1:0] w);
        if (d == 0) begin
            fq0.push_back(w);
            mq0.push_back(w);
        end else begin
            fq1.push_back(w);
            mq1.push_back(w);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((fq0.size() > 0 || fq1.size() > 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check_value("drain_timeout", 32'(fq0.size() + fq1.size()), 0);
        repeat (4) tick();
    endtask

    task automatic pulse_init();
        init = 1'b1;
        tick();
        init = 1'b0;
        tick();
    endtask

    task automatic read_cnt(input int i, input int exp, input string tag);
        idle = 1'b1;
        req = 1'b1;
        idx = 2'(i);
        tick();
        req = 1'b0;
        idle = 1'b0;
        @(negedge clk);
        check_value(tag, cnt_data, 32'(exp));
        check_value({tag, "_v"}, cnt_valid, 1);
        tick();
    endtask

    int rst_left;
    logic [BW-1:0] w;

    initial begin
        // Reset held with both FIFOs loaded: no pops, outputs zero; then D0 first.
        push(0, 6'h01);
        push(1, 6'h31);
        repeat (3) tick();
        reset_L = 1'b1;
        @(negedge clk);
        check_value("first_rd_d0", D0_rd, 1);
        check_value("first_rd_d1", D1_rd, 0);
        drain();

        // Mixed D0/D1 burst alternates, starting with D0.
        pulse_init();
        push(0, 6'h21); push(0, 6'h2C); push(0, 6'h21);
        push(1, 6'h3F); push(1, 6'h35);
        drain();

        // Pause one cycle after the first pop.
        pulse_init();
        push(0, 6'h02); push(0, 6'h03);
        push(1, 6'h12); push(1, 6'h13);
        tick();
        tick();
        pause = 1'b1;
        repeat (4) tick();
        pause = 1'b0;
        drain();

        // Counts after 4 D0 + 3 D1 words.
        pulse_init();
        for (int i = 0; i < 4; i++) push(0, 6'(i));
        for (int i = 0; i < 3; i++) push(1, 6'h10 | 6'(i));
        drain();
        read_cnt(0, 4, "cnt_d0_4");
        read_cnt(1, 3, "cnt_d1_3");
        read_cnt(2, 7, "cnt_tot_7");
        req = 1'b1;
        idx = 2'd2;
        tick();
        req = 1'b0;
        @(negedge clk);
        check_value("cnt_valid_not_idle", cnt_valid, 0);
        tick();

        // Saturation with 40 D1 words, then clear.
        pulse_init();
        for (int i = 0; i < 40; i++) push(1, 6'h10 | 6'($urandom_range(0, 15)));
        drain();
        read_cnt(1, CntMax, "sat_d1");
        read_cnt(2, CntMax, "sat_tot");
        read_cnt(0, 0, "sat_d0_zero");
        pulse_init();
        read_cnt(2, 0, "tot_after_init");

        // Misrouted word in D1.
        pulse_init();
        push(1, 6'h21);
        drain();
`ifdef MISROUTE_CHECK_EN
        read_cnt(3, 1, "misroute_1");
`else
        read_cnt(3, 0, "misroute_off");
`endif

        // Randomized traffic, control and occasional mid-stream reset.
        rst_left = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 4) < 2) begin
                w = BW'($urandom);
                push(0, w);
            end
            if ($urandom_range(0, 4) < 2) begin
                w = BW'($urandom);
                push(1, w);
            end
            pause = ($urandom_range(0, 7) == 0);
            init = ($urandom_range(0, 63) == 0);
            idle = 1'($urandom_range(0, 1));
            req = 1'($urandom_range(0, 1));
            idx = 2'($urandom_range(0, 3));
            if (rst_left > 0) begin
                reset_L = 1'b0;
                rst_left--;
            end else begin
                reset_L = 1'b1;
                if ($urandom_range(0, 499) == 0) begin
                    reset_L = 1'b0;
                    rst_left = 1;
                end
            end
        end
        pause = 1'b0;
        init = 1'b0;
        req = 1'b0;
        idle = 1'b0;
        reset_L = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/contador_salida.md
# contador_salida

Output drain stage downstream of the D0/D1 destination FIFOs in the PCIe QoS datapath. Pops words from both destination FIFOs with round-robin arbitration and presents them on a single registered output stream tagged with their source destination. Keeps saturating per-destination word counters, which the bench or the host reads through a req/idx port while the flow-control FSM reports idle.

## Interface

Parameters:
- BW, 6, word width; bit BW-2 is the destination bit.
- CW, 5, counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_L  in  1  asynchronous, active-low reset.
- init  in  1  synchronous clear of counters and arbitration pointer.
- pause  in  1  when 1, no new FIFO reads are issued.
- idle  in  1  idle_out from the flow-control FSM; enables counter readout.
- D0_empty, D1_empty  in  1 each  destination FIFO empty flags.
- D0_data_out, D1_data_out  in  BW each  FIFO read data, valid the cycle after the corresponding rd.
- D0_rd, D1_rd  out  1 each  FIFO pop strobes; at most one is high per cycle.
- data_out  out  BW  drained word (registered).
- valid_out  out  1  data_out holds a new word this cycle.
- dest_out  out  1  source FIFO of data_out: 0 = D0, 1 = D1.
- req  in  1  counter read request.
- idx  in  2  counter select: 0 = D0 words, 1 = D1 words, 2 = total words, 3 = misrouted words.
- cnt_data  out  CW  selected counter value (registered).
- cnt_valid  out  1  cnt_data is valid.

## Operation

- Reset (reset_L = 0): all registers clear immediately.
  - D0_rd = D1_rd = 0, data_out = 0, valid_out = 0, dest_out = 0, cnt_data = 0, cnt_valid = 0.
  - All counters = 0; pointer last = 1, so D0 is preferred first.
- Arbitration (combinational on rd):
  - Candidates are FIFOs with empty = 0; no candidates when pause = 1 or init = 1.
  - With one candidate, read it.
  - With two candidates, read the one not equal to `last`.
  - `last` updates to the chosen FIFO at the clock edge.
- Capture:
  - A one-stage flag pair records which rd was issued.
  - On the next edge, the matching Dx_data_out is loaded into data_out, dest_out is set, and valid_out is 1 for one cycle.
  - valid_out is 0 on every cycle without a capture; data_out and dest_out hold their last value.
- Counters (on capture):
  - The counter for dest_out and the total counter increment by 1, saturating at 2^CW-1 (no wrap).
  - A misroute occurs when word bit BW-2 differs from the source FIFO index; the misroute counter then increments, saturating.
  - Each counter saturates independently.
- init:
  - Clears all counters and sets last = 1 on the edge.
  - Clear wins over an increment in the same cycle.
  - An in-flight capture is still emitted on valid_out but is not counted.
- Readout:
  - If idle = 1 and req = 1 at an edge: cnt_data is loaded with counter[idx] and cnt_valid = 1 on the next cycle.
  - Otherwise cnt_valid = 0 and cnt_data = 0.
  - Readout does not modify counters; a capture in the same cycle returns the pre-increment value.
- pause:
  - Blocks new reads only; a read issued the cycle before pause still completes.
- Reset mid-operation: an in-flight capture is discarded and nothing is emitted.

## Timing

- rd high in cycle t, so the FIFO data is valid in cycle t+1, and valid_out, data_out and counters update in cycle t+2. Latency is 2 cycles.
- Throughput is 1 word/cycle when at least one FIFO is non-empty.
- Both FIFOs continuously non-empty gives strict alternation D0, D1, D0, …
- Readout latency is 1 cycle from req.
- The empty flag is trusted in the cycle it is asserted; no read is issued to an empty FIFO.

## Configuration

- MISROUTE_CHECK_EN
  - Defined: misroute comparison and counter are built; idx = 3 returns the misroute count.
  - Undefined: no comparison logic or counter; idx = 3 returns 0 with cnt_valid = 1.

## Test plan

- Reset with D0/D1 non-empty, reset_L low for 2 cycles: all outputs stay 0 and no rd is asserted. After release, the first rd is D0_rd.
- D0 holds 3 words (0x21, 0x2C, 0x21) and D1 holds 2 words (0x3F, 0x35):
  - rd sequence is D0, D1, D0, D1, D0 on consecutive cycles.
  - valid_out is high for 5 cycles starting 2 cycles after the first rd, with matching data and dest_out.
- pause raised one cycle after the first rd: exactly one word appears on valid_out. After pause drops, draining resumes with the other FIFO if both are non-empty.
- After draining 4 D0 + 3 D1 words, with idle = 1, req with idx = 0, 1, 2 returns 4, 3, 7 on cnt_data, each one cycle after req. With idle = 0, cnt_valid stays 0.
- 40 D1 words with CW = 5: the D1 and total counters read 31, and the D0 counter reads 0. An init pulse, then a req with idx = 2, returns 0.
- With MISROUTE_CHECK_EN defined, 0x21 (bit 4 = 0) placed in D1: idx = 3 reads 1. Without the macro, idx = 3 reads 0.
